instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Clocked fetch front end that drives the 64-bit byte address into the asynchronous read-only instruction memory and samples the returned 32-bit word after a fixed number of wait cycles. Captured words are paired with their PC in a small FIFO and handed to decode over a valid/ready handshake. A redirect input (taken branch, CBZ, B) flushes queued words and restarts fetch at a new PC.

Parameters:
RD_WAIT, 2, whole cycles between an Address change and the cycle Data is sampled; must be 1 to 15.
FIFO_DEPTH, 2, instruction/PC entries buffered; power of two, 2 to 8.
RESET_PC, 64'h0, fetch address after reset.

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Address  output  64  registered fetch byte address to instruction memory
Data  input  32  instruction word from memory (combinational, valid RD_WAIT cycles after Address change)
InstrOut  output  32  instruction at FIFO head
PCOut  output  64  byte address of InstrOut
InstrValid  output  1  FIFO non-empty
InstrReady  input  1  decode accepts head this cycle
Redirect  input  1  one-cycle pulse: flush and refetch
RedirectPC  input  64  new fetch address, sampled when Redirect=1
Stalled  output  1  high while a sampled-ready word is blocked by a full FIFO

Behaviour:
- Reset (async, any time, including mid-wait or mid-redirect): Address=RESET_PC, wait_cnt=RD_WAIT, FIFO empty, InstrValid=0, InstrOut=0, PCOut=0, Stalled=0.
- wait_cnt: if >0, decrement each edge (WAIT state). When 0 (SAMPLE state):
  - space = (count<FIFO_DEPTH) or (InstrValid and InstrReady this cycle).
  - If space: push {Data, Address}, Address<=Address+4 (mod 2^64, wraps silently), wait_cnt<=RD_WAIT.
  - Else: hold Address and wait_cnt=0, Stalled=1 (STALL state); sample on the first cycle with space.
- Dequeue: edge with InstrValid and InstrReady pops head. Push and pop in the same cycle keep count unchanged; push into a full FIFO with simultaneous pop is legal.
- InstrOut/PCOut driven from head register; stable while InstrValid=1 and InstrReady=0. When empty they hold the last value (not checked).
- Redirect=1 at an edge (highest priority, overrides push and pop): FIFO cleared, Address<={RedirectPC[63:2],2'b00} (misaligned low bits dropped), wait_cnt<=RD_WAIT, Stalled<=0. A word sampled that cycle is discarded, and a pop that cycle is not counted as consumed.
- Latency: first word is pushed at edge RD_WAIT+1 after reset release or after a redirect, and InstrValid rises after that edge. Steady-state throughput is one word per RD_WAIT+1 cycles.
- Data is sampled only in SAMPLE state; X on Data in other cycles is ignored. No decoding of instruction contents.
- count width = log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, InstrReady=1, memory loaded with the test-1 program: InstrValid first high after edge 3, head F84003E9/PC 0. Next is F84083EA/PC 4 three cycles later, then F84103EB/PC 8.
- InstrReady=0 from reset: FIFO fills with words at 0x0 and 0x4, Stalled=1, Address holds 0x8. Raise InstrReady: F84003E9 pops, word at 0x8 pushed the same edge, count stays 2.
- Redirect with RedirectPC=0x4c while 2 entries are queued: InstrValid=0 next cycle. After 3 edges head=D2E24689/PC 0x4c, then 0x50 follows.
- Redirect with RedirectPC=0x4F: Address becomes 0x4C, PCOut 0x4C.
- Assert Reset asynchronously mid-wait (no clock edge): Address=0 and InstrValid=0 immediately, then normal fetch from 0x0 after release.
- Redirect and InstrValid&InstrReady in the same edge while a sample is due: no push, FIFO empty, Address=RedirectPC.
- Address 64'hFFFF_FFFF_FFFF_FFFC fetched: next Address=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: drives a registered byte address into an async ROM,
// samples the word RD_WAIT cycles later and queues {instr, pc} pairs for decode.
module instruction_fetch_unit #(
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  output logic [31:0] InstrOut,
  output logic [63:0] PCOut,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        Stalled
);
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [3:0]  WAIT_INIT = 4'(RD_WAIT);

  typedef enum logic [1:0] {S_WAIT, S_SAMPLE, S_STALL} state_t;

  state_t             r_state, w_state_nx;
  logic [3:0]         r_wait;
  logic [63:0]        r_addr;
  logic [31:0]        r_instr [FIFO_DEPTH];
  logic [63:0]        r_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop, w_space, w_push;

  assign InstrValid = (r_count != '0);
  assign w_pop      = InstrValid & InstrReady;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_space    = (r_count < CNT_W'(FIFO_DEPTH)) | w_pop;
  assign Address    = r_addr;
  assign InstrOut   = r_instr[r_rd_ptr];
  assign PCOut      = r_pc[r_rd_ptr];
  assign Stalled    = (r_state == S_STALL);

  always_comb begin
    w_state_nx = r_state;
    w_push     = 1'b0;
    case (r_state)
      S_WAIT:   if (r_wait <= 4'd1) w_state_nx = S_SAMPLE;
      S_SAMPLE,
      S_STALL: begin
        if (w_space) begin
          w_push     = 1'b1;
          w_state_nx = S_WAIT;
        end else begin
          w_state_nx = S_STALL;
        end
      end
      default:  w_state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_WAIT;
      r_wait   <= WAIT_INIT;
      r_addr   <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (Redirect) begin
      // Redirect wins over any push/pop: the sampled word and the pop are both dropped.
      r_state  <= S_WAIT;
      r_wait   <= WAIT_INIT;
      r_addr   <= {RedirectPC[63:2], 2'b00};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_WAIT) r_wait <= r_wait - 4'd1;
      if (w_push) begin
        r_instr[r_wr_ptr] <= Data;
        r_pc[r_wr_ptr]    <= r_addr;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_addr            <= r_addr + 64'd4;
        r_wait            <= WAIT_INIT;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule
